contador_pontos_n: RTL and testbench

CONTADOR_PONTOS_N -- requirements
Module: contador_pontos_n

---
 rtl/contador_pontos_n.sv | 143 ++++++++++++++
 tb/tb_contador_pontos_n.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/contador_pontos_n.sv
// Saturating score counter driven by hit/miss edges, with a derived blocking-line count.
// Optional streak bonus enabled by defining CONTADOR_PONTOS_SEQUENCIA_EN.
module contador_pontos_n #(
    parameter int PONTOS_W   = 6,
    parameter int PONTOS_MAX = 32,
    parameter int PASSO      = 4,
    parameter int LINHAS_W   = 3,
    parameter int LINHAS_MAX = 7,
    parameter int SEQ_N      = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                acertou,
    input  logic                errou,
    input  logic                zera,
    output logic [PONTOS_W-1:0] pontos,
    output logic [LINHAS_W-1:0] linhas_bloq,
    output logic                linhas_sobe,
    output logic                linhas_desce,
    output logic                no_maximo,
    output logic                combo
);

    logic                acertou_q;
    logic                errou_q;
    logic [PONTOS_W-1:0] pontos_q;
    logic [PONTOS_W-1:0] pontos_d;
    logic [LINHAS_W-1:0] linhas_q;
    logic [LINHAS_W-1:0] linhas_d;
    logic                sobe_q;
    logic                desce_q;
    logic                hit_ev_s;
    logic                miss_ev_s;
    logic                hit_ok_s;
    logic                miss_ok_s;
    logic                cancel_s;
    logic [1:0]          inc_s;
    logic                combo_s;
    logic [PONTOS_W:0]   soma_s;
    logic [PONTOS_W-1:0] linhas_full_s;

    // Edge detection and qualification of the events by enable
    always_comb begin
        hit_ev_s  = acertou & ~acertou_q;
        miss_ev_s = errou & ~errou_q;
        hit_ok_s  = enable & hit_ev_s & ~miss_ev_s;
        miss_ok_s = enable & miss_ev_s & ~hit_ev_s;
        cancel_s  = enable & hit_ev_s & miss_ev_s;
    end

    // Next score: zera wins, then a sole hit (one bit wider to avoid wrap) or a sole miss
    always_comb begin
        soma_s   = {1'b0, pontos_q} + (PONTOS_W+1)'(inc_s);
        pontos_d = pontos_q;
        if (zera) begin
            pontos_d = '0;
        end else if (hit_ok_s) begin
            if (soma_s > (PONTOS_W+1)'(PONTOS_MAX)) begin
                pontos_d = PONTOS_W'(PONTOS_MAX);
            end else begin
                pontos_d = soma_s[PONTOS_W-1:0];
            end
        end else if (miss_ok_s && (pontos_q != '0)) begin
            pontos_d = pontos_q - PONTOS_W'(1);
        end else begin
            pontos_d = pontos_q;
        end
    end

    // Line count follows the registered score, clamped to LINHAS_MAX
    always_comb begin
        linhas_full_s = pontos_q / PONTOS_W'(PASSO);
        if (linhas_full_s > PONTOS_W'(LINHAS_MAX)) begin
            linhas_d = LINHAS_W'(LINHAS_MAX);
        end else begin
            linhas_d = LINHAS_W'(linhas_full_s);
        end
    end

`ifdef CONTADOR_PONTOS_SEQUENCIA_EN
    localparam int SEQ_W = $clog2(SEQ_N + 1);

    logic [SEQ_W-1:0] streak_q;
    logic [SEQ_W-1:0] streak_d;

    // Streak counts consecutive sole hits and saturates at SEQ_N
    always_comb begin
        streak_d = streak_q;
        if (zera || miss_ok_s || cancel_s) begin
            streak_d = '0;
        end else if (hit_ok_s && (streak_q != SEQ_W'(SEQ_N))) begin
            streak_d = streak_q + SEQ_W'(1);
        end else begin
            streak_d = streak_q;
        end
        combo_s = (streak_q == SEQ_W'(SEQ_N));
        inc_s   = combo_s ? 2'd2 : 2'd1;
    end

    // Streak register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    // Without the streak feature every hit is worth one point
    always_comb begin
        combo_s = 1'b0;
        inc_s   = 2'd1;
    end
`endif

    // Main state; edge samples reset high so a held input gives no event at release
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acertou_q <= 1'b1;
            errou_q   <= 1'b1;
            pontos_q  <= '0;
            linhas_q  <= '0;
            sobe_q    <= 1'b0;
            desce_q   <= 1'b0;
        end else begin
            acertou_q <= acertou;
            errou_q   <= errou;
            pontos_q  <= pontos_d;
            linhas_q  <= linhas_d;
            sobe_q    <= (linhas_d > linhas_q);
            desce_q   <= (linhas_d < linhas_q);
        end
    end

    assign pontos       = pontos_q;
    assign linhas_bloq  = linhas_q;
    assign linhas_sobe  = sobe_q;
    assign linhas_desce = desce_q;
    assign no_maximo    = (pontos_q == PONTOS_W'(PONTOS_MAX));
    assign combo        = combo_s;

endmodule

// File: tb/tb_contador_pontos_n.sv
// Directed self-checking bench for contador_pontos_n (default parameters).
module tb_contador_pontos_n;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       acertou;
    logic       errou;
    logic       zera;
    logic [5:0] pontos;
    logic [2:0] linhas_bloq;
    logic       linhas_sobe;
    logic       linhas_desce;
    logic       no_maximo;
    logic       combo;

    int n_cmp = 0;
    int n_err = 0;
    int sobe_cnt = 0;
    int desce_cnt = 0;
    int sobe_ref;
    int desce_ref;

    contador_pontos_n dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .acertou     (acertou),
        .errou       (errou),
        .zera        (zera),
        .pontos      (pontos),
        .linhas_bloq (linhas_bloq),
        .linhas_sobe (linhas_sobe),
        .linhas_desce(linhas_desce),
        .no_maximo   (no_maximo),
        .combo       (combo)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (linhas_sobe) sobe_cnt++;
        if (linhas_desce) desce_cnt++;
    endtask

    task automatic hit();
        acertou = 1'b1;
        tick();
        acertou = 1'b0;
        tick();
    endtask

    task automatic miss();
        errou = 1'b1;
        tick();
        errou = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; acertou = 1'b0; errou = 1'b0; zera = 1'b0;
        #2;
        chk("rst_pontos", pontos, 0);
        chk("rst_linhas", linhas_bloq, 0);
        chk("rst_sobe", linhas_sobe, 0);
        chk("rst_desce", linhas_desce, 0);
        chk("rst_combo", combo, 0);
        chk("rst_nomax", no_maximo, 0);

`ifdef CONTADOR_PONTOS_SEQUENCIA_EN
        tick();
        reset = 1'b0;
        tick();
        hit(); hit();
        chk("seq_2hits", pontos, 2);
        chk("seq_combo0", combo, 0);
        hit();
        chk("seq_3hits", pontos, 3);
        chk("seq_combo1", combo, 1);
        hit();
        chk("seq_bonus", pontos, 5);
        miss();
        chk("seq_miss", pontos, 4);
        chk("seq_combo_clr", combo, 0);
`else
        // Input already high at reset release produces no event
        acertou = 1'b1;
        tick();
        reset = 1'b0;
        tick(); tick();
        chk("held_at_release", pontos, 0);
        acertou = 1'b0;
        tick();

        hit(); hit(); hit();
        chk("three_hits", pontos, 3);
        sobe_ref = sobe_cnt;
        acertou = 1'b1;
        tick();
        chk("fourth_hit", pontos, 4);
        chk("linhas_lag", linhas_bloq, 0);
        acertou = 1'b0;
        tick();
        chk("linhas_up", linhas_bloq, 1);
        chk("sobe_pulse", linhas_sobe, 1);
        tick();
        chk("sobe_once", sobe_cnt - sobe_ref, 1);

        desce_ref = desce_cnt;
        errou = 1'b1;
        tick();
        chk("miss_one", pontos, 3);
        errou = 1'b0;
        tick();
        chk("linhas_down", linhas_bloq, 0);
        tick();
        chk("desce_once", desce_cnt - desce_ref, 1);
        for (int i = 0; i < 4; i++) miss();
        chk("no_underflow", pontos, 0);

        for (int i = 0; i < 40; i++) hit();
        chk("sat_pontos", pontos, 32);
        chk("sat_nomax", no_maximo, 1);
        chk("sat_linhas", linhas_bloq, 7);
        hit();
        chk("sat_extra", pontos, 32);

        zera = 1'b1;
        tick();
        zera = 1'b0;
        tick();
        chk("zera_clear", pontos, 0);
        chk("zera_nomax", no_maximo, 0);
        for (int i = 0; i < 5; i++) hit();
        chk("five", pontos, 5);

        acertou = 1'b1; errou = 1'b1;
        tick();
        acertou = 1'b0; errou = 1'b0;
        tick();
        chk("cancel", pontos, 5);

        acertou = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        acertou = 1'b0;
        tick();
        chk("held_once", pontos, 6);

        enable = 1'b0;
        hit(); hit(); hit();
        chk("disabled", pontos, 6);
        enable = 1'b1;
        hit(); hit(); hit();
        chk("nine", pontos, 9);
        chk("nine_linhas", linhas_bloq, 2);
        zera = 1'b1; acertou = 1'b1;
        tick();
        chk("zera_over_hit", pontos, 0);
        zera = 1'b0; acertou = 1'b0;
        tick();
        chk("zera_linhas", linhas_bloq, 0);

        // Reset right after a score change abandons the pending line update
        for (int i = 0; i < 7; i++) hit();
        chk("seven", pontos, 7);
        sobe_ref = sobe_cnt;
        acertou = 1'b1;
        tick();
        chk("eight", pontos, 8);
        reset = 1'b1;
        #2;
        chk("midrst_pontos", pontos, 0);
        reset = 1'b0;
        acertou = 1'b0;
        tick(); tick();
        chk("midrst_nosobe", sobe_cnt - sobe_ref, 0);
        chk("midrst_linhas", linhas_bloq, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
